// File: rtl/zx_keyboard_matrix.sv
// zx_keyboard_matrix
//   Turns the PS/2 set-2 key event stream from the MiST/DeMiSTify glue into
//   the 8x5 ZX Spectrum keyboard matrix and answers ULA port 0xFE reads.
//   One "held" flag is kept per recognised scancode (source). Matrix keys are
//   the OR of all sources that map onto them.
//
// Optional feature (macro ZXKB_COMPOUND_EN):
//   Adds compound keys. Each has its own flag and asserts CAPS SHIFT plus one
//   other key:
//     66 Backspace, 6B Left, 72 Down, 75 Up, 74 Right, 76 Esc.
//   When undefined, those codes are ignored.
//
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-low reset
//   strb   in   one-cycle key event strobe
//   make   in   1 = pressed, 0 = released (qualified by strb)
//   code   in   [7:0] scancode, E0 prefix stripped (qualified by strb)
//   addr   in   [7:0] CPU A15..A8, active-low row select (bit r = row r)
//   keys   out  [4:0] D4..D0, active-low, registered

module zx_keyboard_matrix (
    input  logic       clock,
    input  logic       reset,
    input  logic       strb,
    input  logic       make,
    input  logic [7:0] code,
    input  logic [7:0] addr,
    output logic [4:0] keys
);

    // Sources 0..39 map one-to-one onto matrix position row*5+bit,
    // source 40 is the second shift key, 41..46 are the compound keys.
`ifdef ZXKB_COMPOUND_EN
    localparam int unsigned NSRC = 47;
`else
    localparam int unsigned NSRC = 41;
`endif

    logic [NSRC-1:0] held;
    logic            hit;
    logic [5:0]      idx;
    logic [39:0]     pressed;
    logic [4:0]      colsActive;

    // Scancode -> source index decode
    always_comb begin
        hit = 1'b1;
        idx = '0;
        case (code)
            8'h12: idx = 6'd0;   // LShift -> CS
            8'h1A: idx = 6'd1;
            8'h22: idx = 6'd2;
            8'h21: idx = 6'd3;
            8'h2A: idx = 6'd4;
            8'h1C: idx = 6'd5;
            8'h1B: idx = 6'd6;
            8'h23: idx = 6'd7;
            8'h2B: idx = 6'd8;
            8'h34: idx = 6'd9;
            8'h15: idx = 6'd10;
            8'h1D: idx = 6'd11;
            8'h24: idx = 6'd12;
            8'h2D: idx = 6'd13;
            8'h2C: idx = 6'd14;
            8'h16: idx = 6'd15;
            8'h1E: idx = 6'd16;
            8'h26: idx = 6'd17;
            8'h25: idx = 6'd18;
            8'h2E: idx = 6'd19;
            8'h45: idx = 6'd20;
            8'h46: idx = 6'd21;
            8'h3E: idx = 6'd22;
            8'h3D: idx = 6'd23;
            8'h36: idx = 6'd24;
            8'h4D: idx = 6'd25;
            8'h44: idx = 6'd26;
            8'h43: idx = 6'd27;
            8'h3C: idx = 6'd28;
            8'h35: idx = 6'd29;
            8'h5A: idx = 6'd30;
            8'h4B: idx = 6'd31;
            8'h42: idx = 6'd32;
            8'h3B: idx = 6'd33;
            8'h33: idx = 6'd34;
            8'h29: idx = 6'd35;
            8'h14: idx = 6'd36;  // Ctrl -> SS
            8'h3A: idx = 6'd37;
            8'h31: idx = 6'd38;
            8'h32: idx = 6'd39;
            8'h59: idx = 6'd40;  // RShift -> CS, own flag
`ifdef ZXKB_COMPOUND_EN
            8'h66: idx = 6'd41;
            8'h6B: idx = 6'd42;
            8'h72: idx = 6'd43;
            8'h75: idx = 6'd44;
            8'h74: idx = 6'd45;
            8'h76: idx = 6'd46;
`endif
            default: hit = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held <= '0;
        end else if (strb && hit) begin
            held[idx] <= make;
        end
    end

    // Matrix key = OR of every source mapped onto it
    always_comb begin
        pressed    = held[39:0];
        pressed[0] = held[0] | held[40];
`ifdef ZXKB_COMPOUND_EN
        pressed[0]  = pressed[0] | (|held[46:41]);
        pressed[20] = held[20] | held[41];  // 0
        pressed[19] = held[19] | held[42];  // 5
        pressed[24] = held[24] | held[43];  // 6
        pressed[23] = held[23] | held[44];  // 7
        pressed[22] = held[22] | held[45];  // 8
        pressed[35] = held[35] | held[46];  // SPACE
`endif
    end

    always_comb begin
        colsActive = '0;
        for (int unsigned r = 0; r < 8; r++) begin
            if (!addr[r]) colsActive = colsActive | pressed[r*5 +: 5];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            keys <= '1;
        end else begin
            keys <= ~colsActive;
        end
    end

endmodule
